hall_cond: RTL and testbench
============================

# hall_cond

Hall-sensor conditioning stage sitting directly upstream of `brushless` in the eBike drive path. It takes the three raw, asynchronous hub-motor hall lines and synchronizes and glitch-filters them, then presents a clean `{hallGrn,hallYlw,hallBlu}` to the commutation logic. It also flags invalid and skipped hall states, measures commutation period for speed estimation, and detects stall.

## Interface
Parameters:
- `FILT_CYC`, default 4: number of consecutive clocks a new synchronized hall code must persist before acceptance; legal range 1–15.
- `PER_W`, default 16: width of the period counter and the `period` output.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `hallGrn_raw`  in  1  raw, asynchronous green hall line.
- `hallYlw_raw`  in  1  raw, asynchronous yellow hall line.
- `hallBlu_raw`  in  1  raw, asynchronous blue hall line.
- `hallGrn`  out  1  filtered green hall line, to `brushless`.
- `hallYlw`  out  1  filtered yellow hall line, to `brushless`.
- `hallBlu`  out  1  filtered blue hall line, to `brushless`.
- `hall_vld`  out  1  filtered code is neither 3'b000 nor 3'b111.
- `period`  out  PER_W  clocks between the last two accepted valid transitions; saturates at all-ones.
- `per_vld`  out  1  one-cycle pulse when `period` updates.
- `stall`  out  1  no valid transition within 2^PER_W−1 clocks.
- `err_trans`  out  1  one-cycle pulse on a non-adjacent valid-to-valid transition.
- `dir`  out  1  rotation direction; 1 = forward, 0 = reverse.

## Operation
- The forward cycle, written {G,Y,B}, is 101→100→110→010→011→001→101. The reverse cycle is the same sequence in the opposite order. "Adjacent" means one step in either direction.
- **Synchronizer:** two flops per line (`s1`, `s2`), capturing all three lines together as a 3-bit vector.
- **Filter:** registers `cand[2:0]` and `cnt[3:0]`, evaluated each clock:
  - if `s2 != cand`: `cand<=s2`, `cnt<=0`;
  - else if `cnt != FILT_CYC-1`: `cnt<=cnt+1`;
  - else, if `cand != hall_q`: accept, `hall_q<=cand`.
- The outputs `{hallGrn,hallYlw,hallBlu}` are `hall_q`. Invalid codes (000, 111) are accepted and passed through; `brushless` coasts on them.
- **Accepted transition handling**, with old = `hall_q`, new = `cand`:
  - Valid→valid, adjacent: update `dir` and `period`.
  - Valid→valid, non-adjacent: pulse `err_trans`; `dir` unchanged; `period` still updated.
  - Any transition to or from an invalid code: clear `seen`, reset `per_cnt`, no `per_vld`.
- **Period measurement:**
  - `per_cnt` increments every clock and saturates at all-ones.
  - On an accepted valid→valid transition with `seen=1`: `period<=per_cnt+1` (saturating), pulse `per_vld`, clear `per_cnt`.
  - On the same transition with `seen=0`: set `seen`, clear `per_cnt`, no pulse.
- **Stall:** `stall` sets when `per_cnt` reaches all-ones; at that point `period<=all-ones`. `stall` clears on the next accepted valid→valid transition.

## Timing
- Reset values: `s1=s2=cand=hall_q=000`, `cnt=0`, `hall_vld=0`, `period=all-ones`, `per_vld=0`, `stall=1`, `err_trans=0`, `dir=1`, `seen=0`, `per_cnt=0`.
- Latency: a raw change captured into `s1` at posedge 0 appears on the hall outputs after posedge FILT_CYC+2 (6 clocks at the default).
- Glitch rejection: a raw pulse must be stable for at least FILT_CYC+1 sampling edges to be accepted; anything shorter is dropped and the outputs do not change.
- `hall_vld`, `err_trans`, `per_vld`, `period` and `dir` all update on the same edge as `hall_q`.
- Transition and `per_cnt` saturation in the same cycle: the transition wins. `period<=all-ones`, `per_vld` pulses if `seen=1`, `stall` clears.
- `rst` dominates everything. Asserting it mid-filter or mid-period discards `cand`, `cnt` and `per_cnt`.

## Configuration
- `HALL_DIR_EN` defined: the `dir` register is implemented and updated on adjacent transitions (forward step → 1, reverse step → 0).
- `HALL_DIR_EN` undefined: `dir` is tied to 1 and no direction register exists.
- Adjacency checking and `err_trans` are present in both builds.

## Test plan
- **Reset/latency:** hold raw=101 through reset, release `rst` → `hallGrn/Ylw/Blu=101` and `hall_vld=1` exactly 6 clocks after the first capture edge (default `FILT_CYC`); `stall=1`.
- **Glitch:** from stable 101, drive a 3-clock pulse to 100 → outputs stay 101 and no pulses occur. A 5-clock pulse is accepted.
- **Forward rotation:** step the forward cycle every 1000 clocks for two revolutions → first `per_vld` on the second transition, then `period=1000` each step, `dir=1`, `stall=0`, `err_trans=0`.
- **Reverse plus skip:** step 101→001→011 (`dir=0`), then jump 011→100 → `err_trans` pulses once and `dir` stays 0.
- **Invalid/stall:** drive 000 → `hall_vld=0` with no `per_vld`; then hold 101 for more than 65535 clocks → `stall=1` and `period=16'hFFFF`. The next adjacent step clears `stall` without a `per_vld` pulse.
- **Build check:** compile without `HALL_DIR_EN` and repeat the reverse scenario → `dir` stays 1 and `err_trans` behaves identically.

Source files
------------

// File: rtl/hall_cond.sv
// Hall-sensor conditioning: 2-flop sync, persistence filter, adjacency/period/stall tracking.
// Optional HALL_DIR_EN builds the rotation-direction register; otherwise dir is fixed forward.
module hall_cond #(
  parameter int FILT_CYC = 4,
  parameter int PER_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hallGrn_raw,
  input  logic             hallYlw_raw,
  input  logic             hallBlu_raw,
  output logic             hallGrn,
  output logic             hallYlw,
  output logic             hallBlu,
  output logic             hall_vld,
  output logic [PER_W-1:0] period,
  output logic             per_vld,
  output logic             stall,
  output logic             err_trans,
  output logic             dir
);

  localparam logic [3:0]       CNT_LAST = 4'(FILT_CYC - 1);
  localparam logic [PER_W-1:0] PER_MAX  = '1;

  logic [2:0]       raw;
  logic [2:0]       s1_reg, s2_reg, cand_reg, hall_reg;
  logic [3:0]       cnt_reg;
  logic             seen_reg, hall_vld_reg, per_vld_reg, stall_reg, err_reg;
  logic [PER_W-1:0] per_cnt_reg, period_reg;

  logic             accept, old_ok, new_ok, vv_trans;
  logic             fwd_step, rev_step, per_sat;
  logic [2:0]       idx_old, idx_new;
  logic [PER_W-1:0] per_inc;

  // Position of a code in the forward cycle; 7 marks the two invalid codes.
  function automatic logic [2:0] fwd_idx(input logic [2:0] code);
    case (code)
      3'b101:  fwd_idx = 3'd0;
      3'b100:  fwd_idx = 3'd1;
      3'b110:  fwd_idx = 3'd2;
      3'b010:  fwd_idx = 3'd3;
      3'b011:  fwd_idx = 3'd4;
      3'b001:  fwd_idx = 3'd5;
      default: fwd_idx = 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] idx_next(input logic [2:0] idx);
    idx_next = (idx == 3'd5) ? 3'd0 : 3'(idx + 3'd1);
  endfunction

  assign raw = {hallGrn_raw, hallYlw_raw, hallBlu_raw};

  always_comb begin
    accept   = (s2_reg == cand_reg) && (cnt_reg == CNT_LAST) && (cand_reg != hall_reg);
    idx_old  = fwd_idx(hall_reg);
    idx_new  = fwd_idx(cand_reg);
    old_ok   = (idx_old != 3'd7);
    new_ok   = (idx_new != 3'd7);
    vv_trans = accept && old_ok && new_ok;
    fwd_step = (idx_new == idx_next(idx_old));
    rev_step = (idx_old == idx_next(idx_new));
    per_sat  = (per_cnt_reg == PER_MAX);
    per_inc  = per_sat ? PER_MAX : per_cnt_reg + PER_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg       <= 3'b000;
      s2_reg       <= 3'b000;
      cand_reg     <= 3'b000;
      hall_reg     <= 3'b000;
      cnt_reg      <= 4'd0;
      hall_vld_reg <= 1'b0;
      period_reg   <= PER_MAX;
      per_vld_reg  <= 1'b0;
      stall_reg    <= 1'b1;
      err_reg      <= 1'b0;
      seen_reg     <= 1'b0;
      per_cnt_reg  <= '0;
    end else begin
      s1_reg      <= raw;
      s2_reg      <= s1_reg;
      per_vld_reg <= 1'b0;
      err_reg     <= 1'b0;
      per_cnt_reg <= per_inc;

      if (s2_reg != cand_reg) begin
        cand_reg <= s2_reg;
        cnt_reg  <= 4'd0;
      end else if (cnt_reg != CNT_LAST) begin
        cnt_reg <= cnt_reg + 4'd1;
      end else if (cand_reg != hall_reg) begin
        hall_reg     <= cand_reg;
        hall_vld_reg <= new_ok;
      end

      // A valid-to-valid step outranks counter saturation; saturated per_inc yields all-ones.
      if (vv_trans) begin
        per_cnt_reg <= '0;
        stall_reg   <= 1'b0;
        err_reg     <= !(fwd_step || rev_step);
        if (seen_reg) begin
          period_reg  <= per_inc;
          per_vld_reg <= 1'b1;
        end else begin
          seen_reg <= 1'b1;
        end
      end else begin
        if (accept) begin
          seen_reg    <= 1'b0;
          per_cnt_reg <= '0;
        end
        if (per_sat) begin
          stall_reg  <= 1'b1;
          period_reg <= PER_MAX;
        end
      end
    end
  end

`ifdef HALL_DIR_EN
  logic dir_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_reg <= 1'b1;
    end else if (vv_trans && fwd_step) begin
      dir_reg <= 1'b1;
    end else if (vv_trans && rev_step) begin
      dir_reg <= 1'b0;
    end
  end

  assign dir = dir_reg;
`else
  assign dir = 1'b1;
`endif

  assign {hallGrn, hallYlw, hallBlu} = hall_reg;
  assign hall_vld  = hall_vld_reg;
  assign period    = period_reg;
  assign per_vld   = per_vld_reg;
  assign stall     = stall_reg;
  assign err_trans = err_reg;

endmodule

// File: tb/tb_hall_cond.sv
// Randomized bench for hall_cond against a cycle-level behavioural model of the hall rules.
module tb_hall_cond;

  localparam int FILT_CYC = 4;
  localparam int PER_W    = 16;
  localparam int MAXV     = 65535;
`ifdef HALL_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  raw = 3'b101;
  logic        hallGrn, hallYlw, hallBlu, hall_vld, per_vld, stall, err_trans, dir;
  logic [15:0] period;

  hall_cond #(.FILT_CYC(FILT_CYC), .PER_W(PER_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .hallGrn_raw(raw[2]),
    .hallYlw_raw(raw[1]),
    .hallBlu_raw(raw[0]),
    .hallGrn    (hallGrn),
    .hallYlw    (hallYlw),
    .hallBlu    (hallBlu),
    .hall_vld   (hall_vld),
    .period     (period),
    .per_vld    (per_vld),
    .stall      (stall),
    .err_trans  (err_trans),
    .dir        (dir)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [2:0] fwd_seq [6];
  logic [2:0] hist [$];
  logic [2:0] m_hall;
  bit         m_vld, m_pvld, m_stall, m_err, m_dir, m_seen;
  int         m_pc, m_period;
  bit         chk_en = 1'b0;

  function automatic int pos_of(input logic [2:0] c);
    for (int i = 0; i < 6; i++) if (fwd_seq[i] == c) return i;
    return -1;
  endfunction

  // Model: a code is accepted once the synchronized stream (raw delayed two edges)
  // has shown it for FILT_CYC+1 consecutive edges and it differs from the output.
  always @(posedge clk) begin : model
    logic [2:0] c;
    bit         stable;
    int         po, pn, d;
    if (rst) begin
      m_hall = 3'b000; m_vld = 0; m_pvld = 0; m_stall = 1; m_err = 0;
      m_dir = 1; m_seen = 0; m_pc = 0; m_period = MAXV;
      hist.delete();
      for (int i = 0; i < FILT_CYC + 3; i++) hist.push_front(3'b000);
    end else begin
      c = hist[1];
      stable = 1;
      for (int i = 1; i <= FILT_CYC + 1; i++) if (hist[i] !== c) stable = 0;
      m_pvld = 0;
      m_err  = 0;
      if (stable && c !== m_hall) begin
        po = pos_of(m_hall);
        pn = pos_of(c);
        if (po >= 0 && pn >= 0) begin
          d = (pn - po + 6) % 6;
          if (m_seen) begin
            m_period = (m_pc + 1 > MAXV) ? MAXV : m_pc + 1;
            m_pvld = 1;
          end else begin
            m_seen = 1;
          end
          m_pc = 0;
          m_stall = 0;
          m_err = (d != 1 && d != 5);
          if (DIR_EN && d == 1) m_dir = 1;
          if (DIR_EN && d == 5) m_dir = 0;
        end else begin
          if (m_pc == MAXV) begin
            m_stall = 1;
            m_period = MAXV;
          end
          m_seen = 0;
          m_pc = 0;
        end
        $display("[TB] t=%0t hall %b->%b per_vld=%0d period=%0d err=%0d dir=%0d",
                 $time, m_hall, c, m_pvld, m_period, m_err, m_dir);
        m_hall = c;
        m_vld  = (pn >= 0);
      end else begin
        if (m_pc == MAXV) begin
          m_stall = 1;
          m_period = MAXV;
        end
        m_pc = (m_pc == MAXV) ? MAXV : m_pc + 1;
      end
      hist.push_front(raw);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("hall",      32'({hallGrn, hallYlw, hallBlu}), 32'(m_hall));
      check("hall_vld",  32'(hall_vld),  32'(m_vld));
      check("period",    32'(period),    m_period);
      check("per_vld",   32'(per_vld),   32'(m_pvld));
      check("stall",     32'(stall),     32'(m_stall));
      check("err_trans", 32'(err_trans), 32'(m_err));
      check("dir",       32'(dir),       32'(m_dir));
    end
  end

  task automatic hold(input logic [2:0] c, input int n);
    raw = c;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p, r;
    logic [2:0] nxt;
    fwd_seq = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    rst = 1'b1;
    raw = 3'b101;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_hall",   32'({hallGrn, hallYlw, hallBlu}), 32'h0);
    check("rst_stall",  32'(stall), 32'h1);
    check("rst_period", 32'(period), 32'hFFFF);
    rst = 1'b0;

    // Latency: visible after the 7th edge counting the capture edge as 0
    hold(3'b101, 6);
    check("lat_pre",  32'({hallGrn, hallYlw, hallBlu}), 32'h0);
    hold(3'b101, 1);
    check("lat_post", 32'({hallGrn, hallYlw, hallBlu}), 32'h5);
    check("lat_vld",  32'(hall_vld), 32'h1);
    check("lat_stall", 32'(stall), 32'h1);
    hold(3'b101, 20);

    // Glitches: 3 samples rejected, 5 samples accepted
    hold(3'b100, 3);
    hold(3'b101, 30);
    check("glitch3", 32'({hallGrn, hallYlw, hallBlu}), 32'h5);
    hold(3'b100, 5);
    hold(3'b101, 3);
    check("glitch5", 32'({hallGrn, hallYlw, hallBlu}), 32'h4);
    hold(3'b101, 30);

    // Clear the reference, then two forward revolutions
    hold(3'b000, 30);
    hold(3'b101, 30);
    for (int rev = 0; rev < 2; rev++)
      for (int i = 1; i <= 6; i++) hold(fwd_seq[i % 6], 1000);
    check("fwd_period", 32'(period), 32'd1000);
    check("fwd_dir",    32'(dir), 32'h1);
    check("fwd_stall",  32'(stall), 32'h0);

    // Reverse steps then a skip
    hold(3'b001, 50);
    hold(3'b011, 50);
    check("rev_dir", 32'(dir), DIR_EN ? 32'h0 : 32'h1);
    hold(3'b100, 50);
    check("skip_dir", 32'(dir), DIR_EN ? 32'h0 : 32'h1);

    // Invalid code, then a long hold into stall
    hold(3'b000, 50);
    check("inv_vld", 32'(hall_vld), 32'h0);
    hold(3'b101, 65560);
    check("stall_set",    32'(stall), 32'h1);
    check("stall_period", 32'(period), 32'hFFFF);
    hold(3'b100, 50);
    check("stall_clr",    32'(stall), 32'h0);
    check("stall_noupd",  32'(period), 32'hFFFF);

    // Randomized phase: mostly adjacent steps, some jumps, glitches and resets
    repeat (300) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        hold(raw, 2);
        rst = 1'b0;
      end
      p = pos_of(raw);
      r = int'($urandom_range(0, 3));
      if (p < 0 || r == 0) nxt = 3'($urandom_range(0, 7));
      else if (r == 1) nxt = fwd_seq[(p + 1) % 6];
      else if (r == 2) nxt = fwd_seq[(p + 5) % 6];
      else nxt = raw;
      hold(nxt, int'($urandom_range(1, 25)));
    end
    hold(raw, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
